// File: rtl/soc_dma_cmd_tracker.sv
// Steers tagged DMA commands to N backend channels and returns their IDs in order per channel.
// Command forwarding is combinational. A done pulse returns its ID one cycle later, round-robin, and the grant is held under resp backpressure.
module soc_dma_cmd_tracker #(
  parameter int unsigned NumChannels    = 2,
  parameter int unsigned IdWidth        = 8,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned ChanWidth      = (NumChannels > 1) ? $clog2(NumChannels) : 1,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [ChanWidth-1:0]   cmd_chan_i,
  input  logic [IdWidth-1:0]     cmd_id_i,
  output logic [NumChannels-1:0] chan_req_valid_o,
  input  logic [NumChannels-1:0] chan_req_ready_i,
  input  logic [NumChannels-1:0] chan_done_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [IdWidth-1:0]     resp_id_o,
  output logic [ChanWidth-1:0]   resp_chan_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntWidth-1:0]  MaxCnt   = CntWidth'(MaxOutstanding);
  localparam logic [PtrWidth-1:0]  LastPtr  = PtrWidth'(MaxOutstanding - 1);
  localparam logic [ChanWidth-1:0] LastChan = ChanWidth'(NumChannels - 1);

  typedef enum logic [0:0] {
    ArbFree,
    ArbHold
  } arb_state_e;

  logic [IdWidth-1:0]   id_mem_q   [NumChannels][MaxOutstanding];
  logic [PtrWidth-1:0]  wr_ptr_q   [NumChannels];
  logic [PtrWidth-1:0]  rd_ptr_q   [NumChannels];
  logic [CntWidth-1:0]  usage_q    [NumChannels];
  logic [CntWidth-1:0]  inflight_q [NumChannels];
  logic [CntWidth-1:0]  done_q     [NumChannels];
  logic [ChanWidth-1:0] prio_q;
  logic [ChanWidth-1:0] grant_q;
  arb_state_e           arb_q;
  arb_state_e           arb_d;
  logic                 err_q;

  logic [NumChannels-1:0] full;
  logic [NumChannels-1:0] req_vld;
  logic [NumChannels-1:0] accept;
  logic [NumChannels-1:0] done_ok;
  logic [NumChannels-1:0] done_bad;
  logic [NumChannels-1:0] resp_req;
  logic [NumChannels-1:0] pop;
  logic                   sel_in_range;
  logic                   sel_full;
  logic                   sel_ready;
  logic                   drop;
  logic                   rr_found;
  logic [ChanWidth-1:0]   rr_grant;
  logic [ChanWidth-1:0]   grant;
  logic                   resp_vld;
  logic [IdWidth-1:0]     resp_id;
  logic                   busy;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrWidth'(1);
  endfunction

  // Command decode; an out-of-range channel is swallowed and flagged.
  always_comb begin
    full         = '0;
    req_vld      = '0;
    accept       = '0;
    sel_in_range = 1'b0;
    sel_full     = 1'b0;
    sel_ready    = 1'b0;
    for (int c = 0; c < int'(NumChannels); c++) begin
      full[c] = (usage_q[c] == MaxCnt);
      if (cmd_chan_i == ChanWidth'(c)) begin
        sel_in_range = 1'b1;
        sel_full     = full[c];
        sel_ready    = chan_req_ready_i[c];
      end
    end
    for (int c = 0; c < int'(NumChannels); c++) begin
      req_vld[c] = cmd_valid_i & (cmd_chan_i == ChanWidth'(c)) & ~full[c];
      accept[c]  = req_vld[c] & chan_req_ready_i[c];
    end
    cmd_ready_o = sel_in_range ? (sel_ready & ~sel_full) : 1'b1;
    drop        = cmd_valid_i & ~sel_in_range;
  end

  assign chan_req_valid_o = req_vld;

  always_comb begin
    done_ok  = '0;
    done_bad = '0;
    resp_req = '0;
    busy     = 1'b0;
    for (int c = 0; c < int'(NumChannels); c++) begin
      done_ok[c]  = chan_done_i[c] & (inflight_q[c] != '0);
      done_bad[c] = chan_done_i[c] & (inflight_q[c] == '0);
      resp_req[c] = (done_q[c] != '0);
      busy        = busy | (usage_q[c] != '0);
    end
  end

  // Round-robin: first requester at or above the pointer, else wrap to the lowest.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    for (int c = 0; c < int'(NumChannels); c++) begin
      if (!rr_found && resp_req[c] && (ChanWidth'(c) >= prio_q)) begin
        rr_found = 1'b1;
        rr_grant = ChanWidth'(c);
      end
    end
    for (int c = 0; c < int'(NumChannels); c++) begin
      if (!rr_found && resp_req[c]) begin
        rr_found = 1'b1;
        rr_grant = ChanWidth'(c);
      end
    end
  end

  // A stalled grant is held until its handshake; its done count cannot drop meanwhile.
  always_comb begin
    arb_d    = arb_q;
    grant    = rr_grant;
    resp_vld = rr_found;
    case (arb_q)
      ArbFree: begin
        if (rr_found && !resp_ready_i) arb_d = ArbHold;
      end
      ArbHold: begin
        grant    = grant_q;
        resp_vld = 1'b1;
        if (resp_ready_i) arb_d = ArbFree;
      end
      default: arb_d = ArbFree;
    endcase
  end

  always_comb begin
    pop     = '0;
    resp_id = '0;
    for (int c = 0; c < int'(NumChannels); c++) begin
      if (grant == ChanWidth'(c)) begin
        pop[c]  = resp_vld & resp_ready_i;
        resp_id = id_mem_q[c][rd_ptr_q[c]];
      end
    end
  end

  assign resp_valid_o = resp_vld;
  assign resp_id_o    = resp_id;
  assign resp_chan_o  = grant;
  assign busy_o       = busy;
  assign err_o        = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < int'(NumChannels); c++) begin
        wr_ptr_q[c]   <= '0;
        rd_ptr_q[c]   <= '0;
        usage_q[c]    <= '0;
        inflight_q[c] <= '0;
        done_q[c]     <= '0;
      end
      prio_q  <= '0;
      grant_q <= '0;
      arb_q   <= ArbFree;
      err_q   <= 1'b0;
    end else begin
      for (int c = 0; c < int'(NumChannels); c++) begin
        usage_q[c]    <= usage_q[c] + CntWidth'(accept[c]) - CntWidth'(pop[c]);
        inflight_q[c] <= inflight_q[c] + CntWidth'(accept[c]) - CntWidth'(done_ok[c]);
        done_q[c]     <= done_q[c] + CntWidth'(done_ok[c]) - CntWidth'(pop[c]);
        if (accept[c]) wr_ptr_q[c] <= ptr_inc(wr_ptr_q[c]);
        if (pop[c])    rd_ptr_q[c] <= ptr_inc(rd_ptr_q[c]);
      end
      if (resp_vld && resp_ready_i) begin
        prio_q <= (grant == LastChan) ? '0 : grant + ChanWidth'(1);
      end
      grant_q <= grant;
      arb_q   <= arb_d;
      err_q   <= err_q | drop | (|done_bad);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < int'(NumChannels); c++) begin
      if (accept[c]) id_mem_q[c][wr_ptr_q[c]] <= cmd_id_i;
    end
  end

endmodule

// File: tb/tb_soc_dma_cmd_tracker.sv
// Bench for soc_dma_cmd_tracker: directed scenarios plus random traffic, all outputs checked each cycle against a queue model.
module tb_soc_dma_cmd_tracker;
  localparam int NCH  = 3;
  localparam int IDW  = 8;
  localparam int MAXO = 4;
  localparam int CHW  = 2;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           cmd_valid_i;
  logic           cmd_ready_o;
  logic [CHW-1:0] cmd_chan_i;
  logic [IDW-1:0] cmd_id_i;
  logic [NCH-1:0] chan_req_valid_o;
  logic [NCH-1:0] chan_req_ready_i;
  logic [NCH-1:0] chan_done_i;
  logic           resp_valid_o;
  logic           resp_ready_i;
  logic [IDW-1:0] resp_id_o;
  logic [CHW-1:0] resp_chan_o;
  logic           busy_o;
  logic           err_o;

  always #5 clk_i = ~clk_i;

  soc_dma_cmd_tracker #(
    .NumChannels   (NCH),
    .IdWidth       (IDW),
    .MaxOutstanding(MAXO)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .cmd_valid_i     (cmd_valid_i),
    .cmd_ready_o     (cmd_ready_o),
    .cmd_chan_i      (cmd_chan_i),
    .cmd_id_i        (cmd_id_i),
    .chan_req_valid_o(chan_req_valid_o),
    .chan_req_ready_i(chan_req_ready_i),
    .chan_done_i     (chan_done_i),
    .resp_valid_o    (resp_valid_o),
    .resp_ready_i    (resp_ready_i),
    .resp_id_o       (resp_id_o),
    .resp_chan_o     (resp_chan_o),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-channel ID queues with in-flight / completed counts.
  logic [IDW-1:0] mq[NCH][$];
  int m_infl[NCH];
  int m_done[NCH];
  bit m_err;
  int m_ptr;
  bit m_lock;
  int m_lock_ch;

  function automatic bit m_empty();
    for (int c = 0; c < NCH; c++) if (mq[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_infl[c] = 0;
      m_done[c] = 0;
    end
    m_err  = 1'b0;
    m_ptr  = 0;
    m_lock = 1'b0;
    m_lock_ch = 0;
  endtask

  always @(negedge clk_i) begin : compare
    bit in_rng, e_rdy, e_rv;
    int sel, g, idx;
    logic [NCH-1:0] e_req;
    if (!rst_ni) model_reset();
    sel    = int'(cmd_chan_i);
    in_rng = (sel < NCH);
    e_rdy  = in_rng ? (chan_req_ready_i[sel] && (mq[sel].size() < MAXO)) : 1'b1;
    for (int c = 0; c < NCH; c++) e_req[c] = cmd_valid_i && (sel == c) && (mq[c].size() < MAXO);
    e_rv = 1'b0;
    g    = 0;
    if (m_lock) begin
      e_rv = 1'b1;
      g    = m_lock_ch;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        idx = (m_ptr + i) % NCH;
        if (!e_rv && m_done[idx] > 0) begin
          e_rv = 1'b1;
          g    = idx;
        end
      end
    end
    chk("cmd_ready", cmd_ready_o, e_rdy);
    chk("chan_req_valid", chan_req_valid_o, e_req);
    chk("resp_valid", resp_valid_o, e_rv);
    chk("busy", busy_o, !m_empty());
    chk("err", err_o, m_err);
    if (e_rv) begin
      chk("resp_id", resp_id_o, mq[g][0]);
      chk("resp_chan", resp_chan_o, g);
    end
    if (rst_ni) begin
      for (int c = 0; c < NCH; c++) begin
        if (chan_done_i[c]) begin
          if (m_infl[c] > 0) begin
            m_infl[c]--;
            m_done[c]++;
          end else begin
            m_err = 1'b1;
          end
        end
      end
      if (cmd_valid_i && !in_rng) m_err = 1'b1;
      if (cmd_valid_i && in_rng && e_rdy) begin
        mq[sel].push_back(cmd_id_i);
        m_infl[sel]++;
      end
      if (e_rv && resp_ready_i) begin
        void'(mq[g].pop_front());
        m_done[g]--;
        m_ptr  = (g + 1) % NCH;
        m_lock = 1'b0;
      end else if (e_rv) begin
        m_lock    = 1'b1;
        m_lock_ch = g;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input int ch, input logic [IDW-1:0] id);
    cmd_valid_i = 1'b1;
    cmd_chan_i  = CHW'(ch);
    cmd_id_i    = id;
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && !m_empty(); k++) begin
      for (int c = 0; c < NCH; c++) chan_done_i[c] = (m_infl[c] > 0);
      resp_ready_i = 1'b1;
      step();
    end
    chan_done_i = '0;
    #1 chk("drain_busy", busy_o, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [IDW-1:0] rr_id [3];
    int             rr_ch [3];
    rr_id[0] = 8'h01; rr_ch[0] = 0;
    rr_id[1] = 8'h10; rr_ch[1] = 1;
    rr_id[2] = 8'h02; rr_ch[2] = 0;

    rst_ni           = 1'b0;
    cmd_valid_i      = 1'b0;
    cmd_chan_i       = '0;
    cmd_id_i         = '0;
    chan_req_ready_i = '1;
    chan_done_i      = '0;
    resp_ready_i     = 1'b1;
    step();
    step();
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cmd_ready", cmd_ready_o, 1);
    rst_ni = 1'b1;
    step();

    // Single command on ch1
    cmd_valid_i = 1'b1; cmd_chan_i = 2'd1; cmd_id_i = 8'h11;
    #1 chk("single_req_valid", chan_req_valid_o, 3'b010);
    chk("single_ready", cmd_ready_o, 1);
    step();
    cmd_valid_i = 1'b0;
    step();
    step();
    chan_done_i = 3'b010;
    #1 chk("single_no_early_resp", resp_valid_o, 0);
    step();
    chan_done_i = '0;
    #1 chk("single_resp_valid", resp_valid_o, 1);
    chk("single_resp_id", resp_id_o, 8'h11);
    chk("single_resp_chan", resp_chan_o, 1);
    chk("single_busy", busy_o, 1);
    step();
    #1 chk("single_busy_drop", busy_o, 0);

    // In-order per channel, round-robin across channels
    resp_ready_i = 1'b0;
    issue(0, 8'h01);
    issue(0, 8'h02);
    issue(1, 8'h10);
    chan_done_i = 3'b011;
    step();
    chan_done_i = 3'b001;
    step();
    chan_done_i = '0;
    resp_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("rr_valid", resp_valid_o, 1);
      chk("rr_id", resp_id_o, rr_id[k]);
      chk("rr_chan", resp_chan_o, rr_ch[k]);
      step();
    end
    #1 chk("rr_idle", resp_valid_o, 0);

    // Backpressure with grant lock
    resp_ready_i = 1'b0;
    issue(0, 8'h21);
    issue(1, 8'h31);
    chan_done_i = 3'b001;
    step();
    chan_done_i = 3'b010;
    #1 chk("lock_first_id", resp_id_o, 8'h21);
    step();
    chan_done_i = '0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("lock_hold_valid", resp_valid_o, 1);
      chk("lock_hold_id", resp_id_o, 8'h21);
      chk("lock_hold_chan", resp_chan_o, 0);
      step();
    end
    resp_ready_i = 1'b1;
    #1 chk("lock_release_id", resp_id_o, 8'h21);
    step();
    #1 chk("lock_next_id", resp_id_o, 8'h31);
    chk("lock_next_chan", resp_chan_o, 1);
    step();

    // Full channel
    resp_ready_i = 1'b0;
    for (int k = 0; k < MAXO; k++) begin
      cmd_valid_i = 1'b1; cmd_chan_i = 2'd0; cmd_id_i = 8'h40 + IDW'(k);
      #1 chk("full_fill_ready", cmd_ready_o, 1);
      step();
    end
    cmd_id_i = 8'h44;
    #1 chk("full_ready_low", cmd_ready_o, 0);
    chk("full_req_valid_low", chan_req_valid_o, 3'b000);
    cmd_chan_i = 2'd1; cmd_id_i = 8'h50;
    #1 chk("full_other_ready", cmd_ready_o, 1);
    chk("full_other_req", chan_req_valid_o, 3'b010);
    step();
    cmd_valid_i = 1'b0;
    chan_done_i = 3'b001;
    step();
    chan_done_i = '0;
    cmd_valid_i = 1'b1; cmd_chan_i = 2'd0; cmd_id_i = 8'h44;
    resp_ready_i = 1'b1;
    #1 chk("full_pop_id", resp_id_o, 8'h40);
    chk("full_ready_during_pop", cmd_ready_o, 0);
    step();
    resp_ready_i = 1'b0;
    #1 chk("full_ready_after_pop", cmd_ready_o, 1);
    step();
    cmd_valid_i = 1'b0;
    drain();

    // Simultaneous accept, done and pop on ch0
    resp_ready_i = 1'b0;
    issue(0, 8'h61);
    issue(0, 8'h62);
    chan_done_i = 3'b001;
    step();
    cmd_valid_i = 1'b1; cmd_chan_i = 2'd0; cmd_id_i = 8'h63;
    chan_done_i = 3'b001;
    resp_ready_i = 1'b1;
    #1 chk("simul_ready", cmd_ready_o, 1);
    chk("simul_pop_id", resp_id_o, 8'h61);
    step();
    cmd_valid_i = 1'b0;
    chan_done_i = '0;
    #1 chk("simul_next_valid", resp_valid_o, 1);
    chk("simul_next_id", resp_id_o, 8'h62);
    step();
    #1 chk("simul_done_drained", resp_valid_o, 0);
    chk("simul_busy", busy_o, 1);
    chan_done_i = 3'b001;
    step();
    chan_done_i = '0;
    #1 chk("simul_last_id", resp_id_o, 8'h63);
    step();
    #1 chk("simul_idle_busy", busy_o, 0);

    // Done pulse with nothing in flight
    chan_done_i = 3'b001;
    #1 chk("err_before", err_o, 0);
    step();
    chan_done_i = '0;
    #1 chk("err_bad_done", err_o, 1);
    chk("err_bad_done_busy", busy_o, 0);
    chk("err_bad_done_resp", resp_valid_o, 0);
    rst_ni = 1'b0;
    #1 chk("err_async_clear", err_o, 0);
    step();
    rst_ni = 1'b1;
    step();

    // Out-of-range channel
    cmd_valid_i = 1'b1; cmd_chan_i = 2'd3; cmd_id_i = 8'h77;
    #1 chk("oor_ready", cmd_ready_o, 1);
    chk("oor_req_valid", chan_req_valid_o, 3'b000);
    step();
    cmd_valid_i = 1'b0;
    #1 chk("oor_err", err_o, 1);
    chk("oor_busy", busy_o, 0);
    rst_ni = 1'b0;
    #1 chk("oor_reset_clear", err_o, 0);
    step();
    rst_ni = 1'b1;
    step();

    // Random traffic with a mid-run reset
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) rst_ni = 1'b0;
      if (n == 1503) rst_ni = 1'b1;
      cmd_valid_i      = 1'($urandom_range(1, 0));
      cmd_chan_i       = CHW'($urandom_range(NCH - 1, 0));
      cmd_id_i         = IDW'($urandom);
      chan_req_ready_i = NCH'($urandom);
      for (int c = 0; c < NCH; c++) chan_done_i[c] = (m_infl[c] > 0) && ($urandom_range(2, 0) == 0);
      resp_ready_i     = ($urandom_range(3, 0) != 0);
      step();
    end
    cmd_valid_i      = 1'b0;
    chan_req_ready_i = '1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
